// File: rtl/pool_window_buffer.sv
// Row buffer that assembles non-overlapping 2x2 windows (stride 2) for the max-pooling stage.
// Latency: a window is registered 1 cycle after its bottom-right value is accepted.
// Backpressure: in_ready = !out_valid || out_ready; optional POOL_WIN_IDX_EN adds win_row/win_col.
module pool_window_buffer #(
    parameter int DATA_W = 30,
    parameter int ROW_W  = 24,
    parameter int COL_H  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] win_0,
    output logic [DATA_W-1:0] win_1,
    output logic [DATA_W-1:0] win_2,
    output logic [DATA_W-1:0] win_3,
`ifdef POOL_WIN_IDX_EN
    output logic [$clog2(COL_H/2+1)-1:0] win_row,
    output logic [$clog2(ROW_W/2+1)-1:0] win_col,
`endif
    output logic              frame_done
);

    localparam int CW = $clog2(ROW_W);
    localparam int RW = $clog2(COL_H);

    logic [DATA_W-1:0] line_buf_q [ROW_W];

    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [DATA_W-1:0] held_left_q, held_left_d;
    logic              out_valid_q, out_valid_d;
    logic              frame_done_q, frame_done_d;
    logic [DATA_W-1:0] win_0_q, win_1_q, win_2_q, win_3_q;
    logic [DATA_W-1:0] win_0_d, win_1_d, win_2_d, win_3_d;

    logic accept, col_last, row_last, win_load, lb_we;

`ifdef POOL_WIN_IDX_EN
    localparam int RIW = $clog2(COL_H/2+1);
    localparam int CIW = $clog2(ROW_W/2+1);
    logic [RIW-1:0] win_row_q, win_row_d;
    logic [CIW-1:0] win_col_q, win_col_d;
`endif

    always_comb begin
        in_ready     = !out_valid_q || out_ready;
        accept       = in_valid && in_ready;
        col_last     = (col_q == CW'(ROW_W - 1));
        row_last     = (row_q == RW'(COL_H - 1));
        // Odd row + odd col completes a window; a trailing odd column/row never does.
        win_load     = accept && row_q[0] && col_q[0];
        lb_we        = accept && !row_q[0] && !rst;

        col_d        = col_q;
        row_d        = row_q;
        held_left_d  = held_left_q;
        out_valid_d  = out_valid_q;
        frame_done_d = accept && col_last && row_last;
        win_0_d      = win_0_q;
        win_1_d      = win_1_q;
        win_2_d      = win_2_q;
        win_3_d      = win_3_q;
`ifdef POOL_WIN_IDX_EN
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
`endif

        if (accept) begin
            col_d = col_last ? '0 : col_q + CW'(1);
            if (col_last) begin
                row_d = row_last ? '0 : row_q + RW'(1);
            end
            if (row_q[0] && !col_q[0]) begin
                held_left_d = in_data;
            end
        end

        if (win_load) begin
            out_valid_d = 1'b1;
            win_0_d     = line_buf_q[col_q - CW'(1)];
            win_1_d     = line_buf_q[col_q];
            win_2_d     = held_left_q;
            win_3_d     = in_data;
`ifdef POOL_WIN_IDX_EN
            win_row_d   = RIW'(row_q >> 1);
            win_col_d   = CIW'(col_q >> 1);
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            held_left_q  <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            win_0_q      <= '0;
            win_1_q      <= '0;
            win_2_q      <= '0;
            win_3_q      <= '0;
`ifdef POOL_WIN_IDX_EN
            win_row_q    <= '0;
            win_col_q    <= '0;
`endif
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            held_left_q  <= held_left_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            win_0_q      <= win_0_d;
            win_1_q      <= win_1_d;
            win_2_q      <= win_2_d;
            win_3_q      <= win_3_d;
`ifdef POOL_WIN_IDX_EN
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
`endif
        end
    end

    // Line buffer contents are don't-care after reset, so no reset branch.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            line_buf_q[col_q] <= in_data;
        end
    end

    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign win_0      = win_0_q;
    assign win_1      = win_1_q;
    assign win_2      = win_2_q;
    assign win_3      = win_3_q;
`ifdef POOL_WIN_IDX_EN
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
`endif

endmodule

// File: tb/tb_pool_window_buffer.sv
// Directed bench for pool_window_buffer: 4x4 and 5x5 instances driven from one clock.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_pool_window_buffer;
    localparam int DW = 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic iv4, ir4, or4, ov4, fd4;
    logic [DW-1:0] id4, w40, w41, w42, w43;
    logic iv5, ir5, or5, ov5, fd5;
    logic [DW-1:0] id5, w50, w51, w52, w53;
`ifdef POOL_WIN_IDX_EN
    logic [1:0] wr4, wc4, wr5, wc5;
`endif

    int tests = 0;
    int fails = 0;

    pool_window_buffer #(.DATA_W(DW), .ROW_W(4), .COL_H(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
        .out_ready(or4), .out_valid(ov4), .win_0(w40), .win_1(w41), .win_2(w42), .win_3(w43),
`ifdef POOL_WIN_IDX_EN
        .win_row(wr4), .win_col(wc4),
`endif
        .frame_done(fd4)
    );

    pool_window_buffer #(.DATA_W(DW), .ROW_W(5), .COL_H(5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(iv5), .in_ready(ir5), .in_data(id5),
        .out_ready(or5), .out_valid(ov5), .win_0(w50), .win_1(w51), .win_2(w52), .win_3(w53),
`ifdef POOL_WIN_IDX_EN
        .win_row(wr5), .win_col(wc5),
`endif
        .frame_done(fd5)
    );

    task automatic cyc4(input logic v, input logic [DW-1:0] d, input logic ordy, output logic rdy);
        iv4 = v; id4 = d; or4 = ordy;
        #1 rdy = ir4;
        @(posedge clk); #1;
    endtask

    task automatic cyc5(input logic v, input logic [DW-1:0] d, input logic ordy, output logic rdy);
        iv5 = v; id5 = d; or5 = ordy;
        #1 rdy = ir5;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; iv4 = 1'b0; iv5 = 1'b0; or4 = 1'b1; or5 = 1'b1;
        id4 = '0; id5 = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (ov4 !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", ov4); end
        tests++; if (fd4 !== 1'b0) begin fails++; $display("FAIL reset_frame_done got %b want 0", fd4); end
        tests++; if ({w40, w41, w42, w43} !== '0) begin
            fails++; $display("FAIL reset_win got %h %h %h %h want 0", w40, w41, w42, w43); end
        tests++; if (ir4 !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", ir4); end
        tests++; if (ov5 !== 1'b0) begin fails++; $display("FAIL reset5_out_valid got %b want 0", ov5); end
    endtask

    // Full 4x4 frame of values 0..15 with continuous flow.
    task automatic stream16(input string tag);
        logic rdy;
        logic exp_v;
        for (int v = 0; v < 16; v++) begin
            cyc4(1'b1, DW'(v), 1'b1, rdy);
            exp_v = (v == 5) || (v == 7) || (v == 13) || (v == 15);
            tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL %s_in_ready v=%0d got %b want 1", tag, v, rdy); end
            tests++; if (ov4 !== exp_v) begin fails++; $display("FAIL %s_out_valid v=%0d got %b want %b", tag, v, ov4, exp_v); end
            tests++; if (fd4 !== (v == 15)) begin fails++; $display("FAIL %s_frame_done v=%0d got %b want %b", tag, v, fd4, v == 15); end
            if (exp_v) begin
                tests++;
                if ({w40, w41, w42, w43} !== {DW'(v-5), DW'(v-4), DW'(v-1), DW'(v)}) begin
                    fails++; $display("FAIL %s_win v=%0d got %0d %0d %0d %0d want %0d %0d %0d %0d",
                                      tag, v, w40, w41, w42, w43, v-5, v-4, v-1, v);
                end
`ifdef POOL_WIN_IDX_EN
                tests++;
                if ({wr4, wc4} !== {2'((v/4)/2), 2'((v%4)/2)}) begin
                    fails++; $display("FAIL %s_idx v=%0d got %0d,%0d want %0d,%0d", tag, v, wr4, wc4, (v/4)/2, (v%4)/2);
                end
`endif
            end
        end
        cyc4(1'b0, '0, 1'b1, rdy);
        tests++; if (ov4 !== 1'b0) begin fails++; $display("FAIL %s_idle_valid got %b want 0", tag, ov4); end
        tests++; if (fd4 !== 1'b0) begin fails++; $display("FAIL %s_idle_done got %b want 0", tag, fd4); end
    endtask

    task automatic test_stream();
        do_reset();
        stream16("stream");
    endtask

    task automatic test_stall();
        logic rdy;
        do_reset();
        for (int v = 0; v < 6; v++) cyc4(1'b1, DW'(v), 1'b1, rdy);
        tests++; if (ov4 !== 1'b1) begin fails++; $display("FAIL stall_first_valid got %b want 1", ov4); end
        for (int k = 0; k < 5; k++) begin
            cyc4(1'b1, DW'(6), 1'b0, rdy);
            tests++; if (rdy !== 1'b0) begin fails++; $display("FAIL stall_in_ready k=%0d got %b want 0", k, rdy); end
            tests++; if (ov4 !== 1'b1) begin fails++; $display("FAIL stall_valid k=%0d got %b want 1", k, ov4); end
            tests++; if ({w40, w41, w42, w43} !== {DW'(0), DW'(1), DW'(4), DW'(5)}) begin
                fails++; $display("FAIL stall_hold k=%0d got %0d %0d %0d %0d want 0 1 4 5", k, w40, w41, w42, w43); end
        end
        for (int v = 6; v < 16; v++) begin
            cyc4(1'b1, DW'(v), 1'b1, rdy);
            tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL stall_resume_ready v=%0d got %b want 1", v, rdy); end
            if (v == 7 || v == 13 || v == 15) begin
                tests++;
                if (ov4 !== 1'b1 || {w40, w41, w42, w43} !== {DW'(v-5), DW'(v-4), DW'(v-1), DW'(v)}) begin
                    fails++; $display("FAIL stall_resume_win v=%0d got vld=%b %0d %0d %0d %0d want %0d %0d %0d %0d",
                                      v, ov4, w40, w41, w42, w43, v-5, v-4, v-1, v);
                end
            end else begin
                tests++; if (ov4 !== 1'b0) begin fails++; $display("FAIL stall_resume_valid v=%0d got %b want 0", v, ov4); end
            end
        end
        tests++; if (fd4 !== 1'b1) begin fails++; $display("FAIL stall_frame_done got %b want 1", fd4); end
    endtask

    task automatic test_signed();
        logic rdy;
        logic [DW-1:0] d [16];
        for (int i = 0; i < 16; i++) d[i] = DW'(i);
        d[0] = 30'h3FFFFFFF; d[5] = 30'h20000000; d[10] = 30'h20000000; d[15] = 30'h3FFFFFFF;
        do_reset();
        for (int v = 0; v < 16; v++) begin
            cyc4(1'b1, d[v], 1'b1, rdy);
            if (v == 5 || v == 7 || v == 13 || v == 15) begin
                tests++;
                if (ov4 !== 1'b1 || {w40, w41, w42, w43} !== {d[v-5], d[v-4], d[v-1], d[v]}) begin
                    fails++; $display("FAIL signed_win v=%0d got vld=%b %h %h %h %h want %h %h %h %h",
                                      v, ov4, w40, w41, w42, w43, d[v-5], d[v-4], d[v-1], d[v]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic rdy;
        do_reset();
        for (int v = 0; v < 6; v++) cyc4(1'b1, DW'(100 + v), 1'b1, rdy);
        tests++; if (ov4 !== 1'b1) begin fails++; $display("FAIL midrst_pre_valid got %b want 1", ov4); end
        rst = 1'b1;
        cyc4(1'b1, DW'(106), 1'b1, rdy);
        rst = 1'b0;
        tests++; if (ov4 !== 1'b0) begin fails++; $display("FAIL midrst_valid got %b want 0", ov4); end
        tests++; if ({w40, w41, w42, w43} !== '0) begin
            fails++; $display("FAIL midrst_win got %0d %0d %0d %0d want 0", w40, w41, w42, w43); end
        stream16("midrst");
    endtask

    task automatic test_odd();
        logic rdy;
        logic exp_v;
        do_reset();
        for (int v = 0; v < 25; v++) begin
            cyc5(1'b1, DW'(v), 1'b1, rdy);
            exp_v = (v == 6) || (v == 8) || (v == 16) || (v == 18);
            tests++; if (ov5 !== exp_v) begin fails++; $display("FAIL odd_valid v=%0d got %b want %b", v, ov5, exp_v); end
            tests++; if (fd5 !== (v == 24)) begin fails++; $display("FAIL odd_frame_done v=%0d got %b want %b", v, fd5, v == 24); end
            if (exp_v) begin
                tests++;
                if ({w50, w51, w52, w53} !== {DW'(v-6), DW'(v-5), DW'(v-1), DW'(v)}) begin
                    fails++; $display("FAIL odd_win v=%0d got %0d %0d %0d %0d want %0d %0d %0d %0d",
                                      v, w50, w51, w52, w53, v-6, v-5, v-1, v);
                end
            end
            if (v == 7) begin
                for (int g = 0; g < 3; g++) begin
                    cyc5(1'b0, DW'(999), 1'b1, rdy);
                    tests++; if (ov5 !== 1'b0) begin fails++; $display("FAIL odd_gap_valid g=%0d got %b want 0", g, ov5); end
                end
            end
        end
        cyc5(1'b0, '0, 1'b1, rdy);
        tests++; if (fd5 !== 1'b0) begin fails++; $display("FAIL odd_done_width got %b want 0", fd5); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_signed();
        test_mid_reset();
        test_odd();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pool_window_buffer.md
Name: pool_window_buffer

Overview:
- Upstream neighbour of the 2x2 max-pooling stage.
- Accepts the convolution stage's raster-ordered stream of signed 30-bit feature values, one per accepted cycle.
- Buffers one feature-map row and assembles non-overlapping 2x2 windows (stride 2).
- Presents each window as four registered words plus a valid strobe that drives the pooling stage's enable.

Parameters:
DATA_W, 30, width of each signed feature value
ROW_W, 24, feature-map width in values per row
COL_H, 24, feature-map height in rows

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_data holds a valid feature value
in_ready  output  1  block can accept in_data this cycle
in_data  input  DATA_W  signed feature value, raster order (row-major)
out_ready  input  1  downstream consumes the window this cycle
out_valid  output  1  window words are valid
win_0  output  DATA_W  top-left value
win_1  output  DATA_W  top-right value
win_2  output  DATA_W  bottom-left value
win_3  output  DATA_W  bottom-right value
frame_done  output  1  one-cycle pulse after the last value of a frame is accepted

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: out_valid=0, frame_done=0, win_0..3=0, column counter=0, row counter=0, held-left register=0. Line-buffer contents are not cleared; they are don't-care.
- Accept condition: accept = in_valid && in_ready.
- Ready rule: in_ready = !out_valid || out_ready. This is combinational, so there is no bubble under continuous flow.
- Counters: col counts 0..ROW_W-1 and row counts 0..COL_H-1, advancing only on accept.
- col wraps to 0 after ROW_W-1, and row increments at that point.
- row wraps to 0 after COL_H-1 together with col. On that same accept, frame_done pulses for the next cycle.
- Even row: line_buf[col] <= in_data on accept. No window is produced.
- Odd row, even col: held_left <= in_data.
- Odd row, odd col: on accept, the window registers load on the next edge and out_valid=1 (latency 1 cycle):
  - win_0 = line_buf[col-1]
  - win_1 = line_buf[col]
  - win_2 = held_left
  - win_3 = in_data
- Output hold: win_0..3 stay stable while out_valid && !out_ready.
- out_valid clears on the cycle after out_ready=1, unless a new window is loaded that same cycle (back-to-back case). In the back-to-back case out_valid stays 1 with the new data.
- Odd dimensions: floor pooling. A trailing odd column or odd row is accepted and counted but never forms a window.
- Arithmetic: pure data movement, no sign extension or modification. Values are treated as signed only for downstream.
- Reset mid-frame: counters return to 0 and any pending window is dropped (out_valid=0). The next accepted value is row 0, col 0.
- rst has priority over accept in the same cycle.
- in_valid deasserted mid-row: counters hold, with no timeout.
- Implementation:
  - Line buffer is ROW_W x DATA_W registers or inferred RAM, single write port and two combinational read ports.
  - A dual read of col-1 and col is acceptable; an alternative is to latch line_buf[col-1] at even col.

Optional Feature:
- Macro: POOL_WIN_IDX_EN.
- When defined, adds outputs win_row [$clog2(COL_H/2+1)-1:0] and win_col [$clog2(ROW_W/2+1)-1:0].
- win_row = row>>1 and win_col = col>>1 of the emitted window, registered with and held alongside win_0..3; reset to 0.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- ROW_W=4, COL_H=4, in_valid=1 continuous, out_ready=1, in_data=0..15:
  - windows in order (0,1,4,5), (2,3,6,7), (8,9,12,13), (10,11,14,15);
  - each out_valid exactly 1 cycle after accepting 5, 7, 13, 15;
  - frame_done pulses once, 1 cycle after accepting 15.
- Same stream with out_ready=0 from the first window for 5 cycles:
  - in_ready=0 during the stall;
  - win_0..3 hold (0,1,4,5);
  - no value lost; remaining windows match the previous case.
- Signed passthrough: the frame contains -1 (30'h3FFFFFFF) and -536870912 (30'h20000000) → those exact bit patterns appear unchanged on the win ports.
- rst asserted after 6 accepted values of a 4x4 frame, then stream 0..15 → windows identical to the first scenario; no window emitted from pre-reset data.
- ROW_W=5, COL_H=5, values 0..24 → windows (0,1,5,6), (2,3,7,8), (10,11,15,16), (12,13,17,18); column 4 and row 4 ignored; frame_done after value 24.
- With POOL_WIN_IDX_EN, 4x4 case → (win_row, win_col) = (0,0), (0,1), (1,0), (1,1).
